// File: rtl/seg7_capture_if.sv
// Purpose: bundles the 7-segment scan inputs and the capture results of seg7_capture.
// Latency: none (wires only).
// Backpressure: none; outputs are single-cycle pulses plus held values.
interface seg7_capture_if;
  logic [7:0]  iAn;
  logic [6:0]  iSeg;
  logic [3:0]  oDigit;
  logic [2:0]  oIndex;
  logic        oValid;
  logic        oErr;
  logic [31:0] oFrame;
  logic        oFrameValid;

  // Stimulus side: drives the display lines, observes capture results.
  modport master (
    output iAn, iSeg,
    input  oDigit, oIndex, oValid, oErr, oFrame, oFrameValid
  );

  // Capture block side.
  modport slave (
    input  iAn, iSeg,
    output oDigit, oIndex, oValid, oErr, oFrame, oFrameValid
  );
endinterface

// File: rtl/seg7_capture.sv
// Purpose: snoops a multiplexed active-low 7-seg display and recovers digits and whole 8-digit frames.
// Latency: oValid/oErr high in the cycle after edge k+STABLE_CYCLES+1 for inputs changed before edge k.
// Backpressure: none; results are fire-and-forget pulses. Macro SEG7_CAPTURE_HEX_EN adds A..F decoding.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          iClk,
  input  logic          iRst_n,
  seg7_capture_if.slave bus
);

  typedef enum logic {TRACK, HOLD} stateT;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  logic [7:0]       anMeta, anSync, anPrev;
  logic [6:0]       segMeta, segSync, segPrev;
  logic [3:0]       stableCnt, stableCntNext;
  stateT            state, stateNext;
  logic             sampleChanged;
  logic             evalNow;
  logic             oneSel;
  logic [2:0]       selIndex;
  logic             decodeOk;
  logic [3:0]       decodeVal;
  logic [7:0][3:0]  slots, slotsWithNew;
  logic [7:0]       seen, seenWithNew;
  logic [3:0]       digitQ;
  logic [2:0]       indexQ;
  logic             validQ, errQ, frameValidQ;
  logic [31:0]      frameQ;

  // Two-flop synchronizer; resets to the blank (all-ones) pattern.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      anMeta  <= '1;
      anSync  <= '1;
      segMeta <= '1;
      segSync <= '1;
    end else begin
      anMeta  <= bus.iAn;
      anSync  <= anMeta;
      segMeta <= bus.iSeg;
      segSync <= segMeta;
    end
  end

  assign sampleChanged = ({anSync, segSync} != {anPrev, segPrev});

  // Previous-sample, stability counter and FSM state registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      anPrev    <= '1;
      segPrev   <= '1;
      stableCnt <= '0;
      state     <= TRACK;
    end else begin
      anPrev    <= anSync;
      segPrev   <= segSync;
      stableCnt <= stableCntNext;
      state     <= stateNext;
    end
  end

  // Next-state logic: evaluation fires only on the single TRACK->HOLD step.
  always_comb begin
    stableCntNext = stableCnt;
    stateNext     = state;
    evalNow       = 1'b0;
    if (sampleChanged) begin
      stableCntNext = 4'd1;
      stateNext     = TRACK;
    end else begin
      case (state)
        TRACK: begin
          if (stableCnt >= CNT_MAX - 4'd1) begin
            stableCntNext = CNT_MAX;
            stateNext     = HOLD;
            evalNow       = 1'b1;
          end else begin
            stableCntNext = stableCnt + 4'd1;
          end
        end
        HOLD: begin
          stableCntNext = CNT_MAX;
        end
        default: begin
          stateNext = TRACK;
        end
      endcase
    end
  end

  assign oneSel = $onehot(~anSync);

  // Position of the low digit-select line; meaningful only when oneSel is set.
  always_comb begin
    selIndex = '0;
    for (int i = 0; i < 8; i++) begin
      if (!anSync[i]) selIndex = 3'(i);
    end
  end

  // Segment pattern (g..a, active-low) to digit value.
  always_comb begin
    decodeOk  = 1'b1;
    decodeVal = 4'd0;
    case (segSync)
      7'b1000000: decodeVal = 4'h0;
      7'b1111001: decodeVal = 4'h1;
      7'b0100100: decodeVal = 4'h2;
      7'b0110000: decodeVal = 4'h3;
      7'b0011001: decodeVal = 4'h4;
      7'b0010010: decodeVal = 4'h5;
      7'b0000010: decodeVal = 4'h6;
      7'b1111000: decodeVal = 4'h7;
      7'b0000000: decodeVal = 4'h8;
      7'b0010000: decodeVal = 4'h9;
`ifdef SEG7_CAPTURE_HEX_EN
      7'b0001000: decodeVal = 4'hA;
      7'b0000011: decodeVal = 4'hB;
      7'b1000110: decodeVal = 4'hC;
      7'b0100001: decodeVal = 4'hD;
      7'b0000110: decodeVal = 4'hE;
      7'b0001110: decodeVal = 4'hF;
`endif
      default:    decodeOk  = 1'b0;
    endcase
  end

  // Slot contents and seen mask as they would be after accepting the current digit.
  always_comb begin
    slotsWithNew           = slots;
    slotsWithNew[selIndex] = decodeVal;
    seenWithNew            = seen | (8'b1 << selIndex);
  end

  // Capture results; a completed mask publishes the frame and starts a new one.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      slots       <= '0;
      seen        <= '0;
      frameQ      <= '0;
      digitQ      <= '0;
      indexQ      <= '0;
      validQ      <= 1'b0;
      errQ        <= 1'b0;
      frameValidQ <= 1'b0;
    end else begin
      validQ      <= 1'b0;
      errQ        <= 1'b0;
      frameValidQ <= 1'b0;
      if (evalNow && oneSel) begin
        if (decodeOk) begin
          digitQ <= decodeVal;
          indexQ <= selIndex;
          slots  <= slotsWithNew;
          validQ <= 1'b1;
          if (seenWithNew == 8'hFF) begin
            frameQ      <= slotsWithNew;
            frameValidQ <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seenWithNew;
          end
        end else begin
          errQ <= 1'b1;
        end
      end
    end
  end

  assign bus.oDigit      = digitQ;
  assign bus.oIndex      = indexQ;
  assign bus.oValid      = validQ;
  assign bus.oErr        = errQ;
  assign bus.oFrame      = frameQ;
  assign bus.oFrameValid = frameValidQ;

endmodule

// File: tb/tb_seg7_capture.sv
// Purpose: self-checking bench for seg7_capture (vector table, directed sequences, random run vs reference model).
// Latency: expects results STABLE_CYCLES+2 cycles after an input change.
// Backpressure: none. Honours SEG7_CAPTURE_HEX_EN to select expected hex behaviour.
`timescale 1ns/1ps
module tb_seg7_capture;
  localparam int S = 4;
`ifdef SEG7_CAPTURE_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif
  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic iClk = 1'b0;
  logic iRst_n;
  seg7_capture_if bus();

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nPass   = 0;
  int cyc = 0, validCnt = 0, errCnt = 0, frameCnt = 0, lastValidCyc = 0, lastErrCyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  logic [14:0] hist [$];
  logic [3:0]  mDigit, mSlot [8];
  logic [2:0]  mIndex;
  logic [7:0]  mSeen;
  logic [31:0] mFrame;

  function automatic logic [14:0] back(input int k);
    return (k < hist.size()) ? hist[hist.size() - 1 - k] : 15'h7FFF;
  endfunction

  function automatic void refDecode(input logic [6:0] seg, output bit ok, output logic [3:0] d);
    ok = 1'b0;
    d  = 4'd0;
    for (int i = 0; i < 16; i++)
      if (PAT[i] == seg && (i < 10 || HEX)) begin
        ok = 1'b1;
        d  = 4'(i);
      end
  endfunction

  logic [14:0] vS;
  int          run, selPos;
  bit          eV, eE, eF, ok;
  logic [3:0]  dd;

  // A pattern is judged once, when the sample two edges back has been identical for exactly S samples.
  always @(posedge iClk) begin
    cyc++;
    eV = 0; eE = 0; eF = 0;
    if (!iRst_n) begin
      hist.delete();
      mDigit = 0; mIndex = 0; mSeen = 0; mFrame = 0;
      for (int i = 0; i < 8; i++) mSlot[i] = 0;
    end else begin
      hist.push_back({bus.iAn, bus.iSeg});
      if (hist.size() > 20) void'(hist.pop_front());
      vS  = back(2);
      run = 1;
      for (int k = 3; k <= S + 3; k++) begin
        if (back(k) != vS) break;
        run++;
      end
      if (run == S && $countones(~vS[14:7]) == 1) begin
        selPos = 0;
        for (int i = 0; i < 8; i++) if (!vS[7 + i]) selPos = i;
        refDecode(vS[6:0], ok, dd);
        if (ok) begin
          eV = 1;
          mDigit = dd;
          mIndex = 3'(selPos);
          mSlot[selPos] = dd;
          mSeen[selPos] = 1'b1;
          if (mSeen == 8'hFF) begin
            eF = 1;
            mSeen = 0;
            for (int i = 0; i < 8; i++) mFrame[4*i +: 4] = mSlot[i];
          end
        end else begin
          eE = 1;
        end
      end
    end
    #1;
    check("pulses", 64'({bus.oValid, bus.oErr, bus.oFrameValid}), 64'({eV, eE, eF}));
    check("digit_index", 64'({bus.oDigit, bus.oIndex}), 64'({mDigit, mIndex}));
    check("frame", 64'(bus.oFrame), 64'(mFrame));
    if (bus.oValid || bus.oErr) check("valid_err_excl", 64'(bus.oValid & bus.oErr), 64'd0);
    if (bus.oValid)      begin validCnt++; lastValidCyc = cyc; end
    if (bus.oErr)        begin errCnt++;   lastErrCyc   = cyc; end
    if (bus.oFrameValid) frameCnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int hold);
    bus.iAn  = an;
    bus.iSeg = seg;
    repeat (hold) @(negedge iClk);
  endtask

  task automatic driveDigit(input int pos, input int d, input int hold);
    logic [7:0] an;
    an = ~(8'b1 << pos);
    drive(an, PAT[d], hold);
  endtask

  task automatic resetDut(input int n);
    iRst_n   = 1'b0;
    bus.iAn  = '1;
    bus.iSeg = '1;
    repeat (n) @(negedge iClk);
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);
  endtask

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         hold;
    int         nV;
    int         nE;
    logic [3:0] dig;
    logic [2:0] idx;
  } vecT;

  vecT tbl [9];
  int  v0, e0, f0, c0;

  initial begin
    tbl[0] = '{8'hFE, 7'b0110000, 10, 1, 0, 4'd3, 3'd0};
    tbl[1] = '{8'hFD, 7'b1111001, S - 1, 0, 0, 4'd3, 3'd0};
    tbl[2] = '{8'hFC, 7'b0100100, 10, 0, 0, 4'd3, 3'd0};
    tbl[3] = '{8'hFF, 7'b0100100, 10, 0, 0, 4'd3, 3'd0};
    tbl[4] = HEX ? '{8'hFB, 7'b0001000, 10, 1, 0, 4'hA, 3'd2}
                 : '{8'hFB, 7'b0001000, 10, 0, 1, 4'd3, 3'd0};
    tbl[5] = '{8'h7F, 7'b0010000, 10, 1, 0, 4'd9, 3'd7};
    tbl[6] = '{8'hEF, 7'b1111111, 10, 0, 1, 4'd9, 3'd7};
    tbl[7] = '{8'hF7, 7'b0000010, 10, 1, 0, 4'd6, 3'd3};
    tbl[8] = HEX ? '{8'hBF, 7'b1000110, 10, 1, 0, 4'hC, 3'd6}
                 : '{8'hBF, 7'b1000110, 10, 0, 1, 4'd6, 3'd3};

    iRst_n   = 1'b0;
    bus.iAn  = '1;
    bus.iSeg = '1;
    repeat (3) @(negedge iClk);
    check("reset_state",
          64'({bus.oDigit, bus.oIndex, bus.oValid, bus.oErr, bus.oFrameValid, bus.oFrame}), 64'd0);
    iRst_n = 1'b1;
    repeat (4) @(negedge iClk);

    // Vector table: pulse counts, latency, held digit/index.
    for (int i = 0; i < 9; i++) begin
      v0 = validCnt; e0 = errCnt; c0 = cyc;
      drive(tbl[i].an, tbl[i].seg, tbl[i].hold);
      check($sformatf("vec%0d_valid", i), 64'(validCnt - v0), 64'(tbl[i].nV));
      check($sformatf("vec%0d_err", i),   64'(errCnt - e0),   64'(tbl[i].nE));
      check($sformatf("vec%0d_digit", i), 64'({bus.oDigit, bus.oIndex}), 64'({tbl[i].dig, tbl[i].idx}));
      if (tbl[i].nV == 1) check($sformatf("vec%0d_lat", i), 64'(lastValidCyc - c0), 64'(S + 2));
      if (tbl[i].nE == 1) check($sformatf("vec%0d_lat", i), 64'(lastErrCyc - c0),   64'(S + 2));
    end

    // Full scan: digit n at position n.
    resetDut(3);
    v0 = validCnt; f0 = frameCnt;
    for (int d = 0; d < 8; d++) driveDigit(d, d, 8);
    check("scan_valid_count", 64'(validCnt - v0), 64'd8);
    check("scan_frame_count", 64'(frameCnt - f0), 64'd1);
    check("scan_frame", 64'(bus.oFrame), 64'h76543210);
    drive('1, '1, 8);

    // Partial frame discarded by reset.
    v0 = validCnt;
    for (int p = 0; p < 5; p++) driveDigit(p, 9, 8);
    check("partial_valid_count", 64'(validCnt - v0), 64'd5);
    f0 = frameCnt; v0 = validCnt; e0 = errCnt;
    resetDut(3);
    check("reset_no_pulse", 64'((validCnt - v0) + (errCnt - e0) + (frameCnt - f0)), 64'd0);
    check("reset_frame_clear", 64'(bus.oFrame), 64'd0);
    for (int p = 0; p < 7; p++) driveDigit(p, 7 - p, 8);
    check("rescan_no_early_frame", 64'(frameCnt - f0), 64'd0);
    driveDigit(7, 0, 8);
    check("rescan_frame_count", 64'(frameCnt - f0), 64'd1);
    check("rescan_frame", 64'(bus.oFrame), 64'h01234567);

    // Random scan traffic; the per-cycle model comparison does the checking.
    for (int n = 0; n < 250; n++) begin
      int         r, pos;
      logic [7:0] an;
      logic [6:0] seg;
      r   = int'($urandom_range(0, 9));
      pos = int'($urandom_range(0, 7));
      an  = ~(8'b1 << pos);
      if (r == 0) an = '1;
      else if (r == 1) an = an & ~(8'b1 << ((pos + 1) % 8));
      seg = (r == 2) ? 7'($urandom) : PAT[$urandom_range(0, 15)];
      if (n == 120) resetDut(2);
      drive(an, seg, int'($urandom_range(1, 9)));
    end
    drive('1, '1, 10);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
